bram_dual_port: RTL and testbench

//  Parametrised simple-dual-port block RAM: one write port and one read port on one clock.

---
 rtl/bram_dual_port.sv | 182 ++++++++++++++++++
 tb/tb_bram_dual_port.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dual_port.sv
module bram_dual_port #(
    parameter int    BITWIDTH     = 12,
    parameter int    RAMWIDTH     = 32,
    parameter int    LANEWIDTH    = 12,
    parameter int    OUT_REG      = 0,
    parameter int    RDW_MODE     = 0,
    parameter int    CLEAR_ON_RST = 1,
    parameter string DATA_FILE    = "",
    localparam int   NUM_LANES    = BITWIDTH / LANEWIDTH,
    localparam int   AW           = (RAMWIDTH > 1) ? $clog2(RAMWIDTH) : 1
) (
    input  logic                 CLK_RAM,
    input  logic                 RST,
    input  logic                 WR_EN,
    input  logic [AW-1:0]        WR_ADR,
    input  logic [NUM_LANES-1:0] WR_MASK,
    input  logic [BITWIDTH-1:0]  DIN,
    input  logic                 RD_EN,
    input  logic [AW-1:0]        RD_ADR,
    output logic [BITWIDTH-1:0]  DOUT,
    output logic                 DOUT_VALID,
    output logic                 BUSY
);

    localparam logic [AW:0]   DEPTH    = RAMWIDTH[AW:0];
    localparam int            LAST_INT = RAMWIDTH - 1;
    localparam logic [AW-1:0] LAST_ADR = LAST_INT[AW-1:0];

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    logic [BITWIDTH-1:0] mem_q [RAMWIDTH];

    initial begin
        for (int i = 0; i < RAMWIDTH; i++) mem_q[i] = '0;
    end

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clr_we;
    logic          busy;

    assign busy = RST | (state_q == ST_CLEAR);
    assign BUSY = busy;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        if (!RST && state_q == ST_CLEAR) begin
            if (CLEAR_ON_RST != 0) begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_ADR) state_d = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge CLK_RAM) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    logic wr_in_range, rd_in_range;
    logic wr_fire, rd_fire, collide;

    assign wr_in_range = ({1'b0, WR_ADR} < DEPTH);
    assign rd_in_range = ({1'b0, RD_ADR} < DEPTH);
    assign wr_fire     = !busy && WR_EN && wr_in_range;
    assign rd_fire     = !busy && RD_EN;
    assign collide     = wr_fire && rd_fire && (WR_ADR == RD_ADR);

    logic                 mem_we;
    logic [AW-1:0]        mem_wadr;
    logic [NUM_LANES-1:0] mem_lane_en;
    logic [BITWIDTH-1:0]  mem_wdata;

    always_comb begin
        mem_we      = 1'b0;
        mem_wadr    = WR_ADR;
        mem_lane_en = WR_MASK;
        mem_wdata   = DIN;
        if (clr_we) begin
            mem_we      = 1'b1;
            mem_wadr    = clr_cnt_q;
            mem_lane_en = '1;
            mem_wdata   = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK_RAM) begin
        if (mem_we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (mem_lane_en[l])
                    mem_q[mem_wadr][l*LANEWIDTH +: LANEWIDTH] <=
                        mem_wdata[l*LANEWIDTH +: LANEWIDTH];
            end
        end
    end

    logic [BITWIDTH-1:0] rd_old;
    logic [BITWIDTH-1:0] rd_merged;
    logic [BITWIDTH-1:0] rd_word;

    always_comb begin
        rd_old = '0;
        if (rd_in_range) rd_old = mem_q[RD_ADR];
    end

    always_comb begin
        rd_merged = rd_old;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (WR_MASK[l])
                rd_merged[l*LANEWIDTH +: LANEWIDTH] = DIN[l*LANEWIDTH +: LANEWIDTH];
        end
    end

    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == 1 && collide) rd_word = rd_merged;
    end

    logic [BITWIDTH-1:0] s1_data_q, s1_data_d;
    logic                s1_vld_q,  s1_vld_d;

    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = rd_fire;
        if (rd_fire) s1_data_d = rd_word;
    end

    always_ff @(posedge CLK_RAM) begin
        if (RST) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_lat1
            assign DOUT       = s1_data_q;
            assign DOUT_VALID = s1_vld_q;
        end else begin : g_lat2
            logic [BITWIDTH-1:0] dout_q, dout_d;
            logic                dvld_q, dvld_d;

            always_comb begin
                dout_d = dout_q;
                dvld_d = s1_vld_q;
                if (s1_vld_q) dout_d = s1_data_q;
            end

            always_ff @(posedge CLK_RAM) begin
                if (RST) begin
                    dout_q <= '0;
                    dvld_q <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dvld_q <= dvld_d;
                end
            end

            assign DOUT       = dout_q;
            assign DOUT_VALID = dvld_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dual_port.sv
// ---------------------------------------------------------------------------
// tb_bram_dual_port
//   Three configurations driven by one shared stimulus stream:
//     A: RAMWIDTH 20, 4-bit lanes, latency 1, READ_FIRST,  clear after reset
//     B: RAMWIDTH 32, 4-bit lanes, latency 2, WRITE_FIRST, clear after reset
//     C: RAMWIDTH 32, one lane,    latency 1, WRITE_FIRST, contents kept
//   A behavioural model (array + per-instance result queue) predicts every
//   output; directed scenarios add literal expectations, then a random run.
// ---------------------------------------------------------------------------
module tb_bram_dual_port;

    localparam int NI = 3;
    localparam int P_RW  [NI] = '{20, 32, 32};
    localparam int P_LW  [NI] = '{4, 4, 12};
    localparam int P_LAT [NI] = '{1, 2, 1};
    localparam int P_RDW [NI] = '{0, 1, 1};
    localparam int P_CLR [NI] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [4:0]  wa, ra;
    logic [2:0]  wm;
    logic [11:0] din;
    logic [11:0] dout [NI];
    logic        vld  [NI];
    logic        busy [NI];

    always #5 clk = ~clk;

    bram_dual_port #(.BITWIDTH(12), .RAMWIDTH(20), .LANEWIDTH(4), .OUT_REG(0),
                     .RDW_MODE(0), .CLEAR_ON_RST(1), .DATA_FILE("")) u_a (
        .CLK_RAM(clk), .RST(rst), .WR_EN(we), .WR_ADR(wa), .WR_MASK(wm), .DIN(din),
        .RD_EN(re), .RD_ADR(ra), .DOUT(dout[0]), .DOUT_VALID(vld[0]), .BUSY(busy[0]));

    bram_dual_port #(.BITWIDTH(12), .RAMWIDTH(32), .LANEWIDTH(4), .OUT_REG(1),
                     .RDW_MODE(1), .CLEAR_ON_RST(1), .DATA_FILE("")) u_b (
        .CLK_RAM(clk), .RST(rst), .WR_EN(we), .WR_ADR(wa), .WR_MASK(wm), .DIN(din),
        .RD_EN(re), .RD_ADR(ra), .DOUT(dout[1]), .DOUT_VALID(vld[1]), .BUSY(busy[1]));

    bram_dual_port #(.BITWIDTH(12), .RAMWIDTH(32), .LANEWIDTH(12), .OUT_REG(0),
                     .RDW_MODE(1), .CLEAR_ON_RST(0), .DATA_FILE("")) u_c (
        .CLK_RAM(clk), .RST(rst), .WR_EN(we), .WR_ADR(wa), .WR_MASK(wm[0:0]), .DIN(din),
        .RD_EN(re), .RD_ADR(ra), .DOUT(dout[2]), .DOUT_VALID(vld[2]), .BUSY(busy[2]));

    // ---------------- behavioural model ----------------
    typedef struct packed { logic v; logic [11:0] d; } ent_t;

    logic [11:0] mm [NI][32];
    int          clr_left [NI];
    logic [11:0] m_dout [NI];
    logic        m_vld  [NI];
    ent_t        pq [NI][$];

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 1'b0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 32; a++) mm[i][a] = '0;
            clr_left[i] = 0;
            m_dout[i] = '0;
            m_vld[i] = 1'b0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Effect of one clock edge given the inputs currently applied.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                clr_left[i] = (P_CLR[i] != 0) ? P_RW[i] : 1;
                pq[i].delete();
                m_dout[i] = '0;
                m_vld[i] = 1'b0;
            end else begin
                ent_t        e;
                logic [11:0] nw;
                e = '0;
                if (clr_left[i] > 0) begin
                    clr_left[i]--;
                    if (P_CLR[i] != 0 && clr_left[i] == 0)
                        for (int a = 0; a < 32; a++) mm[i][a] = '0;
                end else begin
                    if (re) begin
                        e.v = 1'b1;
                        e.d = (int'(ra) < P_RW[i]) ? mm[i][ra] : 12'h000;
                    end
                    if (we && int'(wa) < P_RW[i]) begin
                        nw = mm[i][wa];
                        for (int b = 0; b < 12; b++)
                            if (wm[b / P_LW[i]]) nw[b] = din[b];
                        if (re && ra == wa && P_RDW[i] == 1) e.d = nw;
                        mm[i][wa] = nw;
                    end
                end
                pq[i].push_back(e);
                if (pq[i].size() >= P_LAT[i]) begin
                    e = pq[i].pop_front();
                    if (e.v) m_dout[i] = e.d;
                    m_vld[i] = e.v;
                end else begin
                    m_vld[i] = 1'b0;
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("dout[%0d]", i), int'(dout[i]), int'(m_dout[i]));
                check($sformatf("dout_valid[%0d]", i), int'(vld[i]), int'(m_vld[i]));
                check($sformatf("busy[%0d]", i), int'(busy[i]),
                      int'(rst || clr_left[i] > 0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; wa = '0; ra = '0; wm = '0; din = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [11:0] d, input logic [2:0] m);
        we = 1'b1; wa = a; din = d; wm = m;
    endtask

    // Count cycles with BUSY high after RST falls; optionally throw strobes
    // at the port while every clearing instance is still busy.
    task automatic busy_len(input bit strobes, output int cnt [NI]);
        for (int i = 0; i < NI; i++) cnt[i] = 0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NI; i++) if (busy[i]) cnt[i]++;
            if (strobes && clr_left[0] > 0 && clr_left[1] > 0) begin
                we = 1'b1; re = 1'b1; wm = 3'b111;
                wa = 5'($urandom_range(0, 31)); ra = 5'($urandom_range(0, 31));
                din = 12'($urandom_range(1, 4095));
            end else begin
                idle();
            end
            tick();
        end
        idle();
    endtask

    int cnt [NI];
    logic [11:0] or_a, or_b;
    int nvld_a;

    initial begin
        rst = 1'b1;
        idle();
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Clear length after reset
        busy_len(1'b0, cnt);
        check("busy_len_a", cnt[0], 20);
        check("busy_len_b", cnt[1], 32);
        check("busy_len_c", cnt[2], 1);

        // Write then read, latency 1 and 2
        wr(5, 12'hABC, 3'b111); tick(); idle();
        re = 1'b1; ra = 5; tick(); idle();
        check("lat1_a_data", int'(dout[0]), 'hABC);
        check("lat1_a_valid", int'(vld[0]), 1);
        check("lat1_c_data", int'(dout[2]), 'hABC);
        tick();
        check("lat2_b_data", int'(dout[1]), 'hABC);
        check("lat2_b_valid", int'(vld[1]), 1);
        check("lat1_a_hold_novalid", int'(vld[0]), 0);

        // Lane mask
        wr(7, 12'h123, 3'b111); tick();
        wr(7, 12'hFFF, 3'b010); tick(); idle();
        re = 1'b1; ra = 7; tick(); idle();
        check("mask_a", int'(dout[0]), 'h1F3);
        check("mask_c_lane0_off", int'(dout[2]), 'h123);
        tick();
        check("mask_b", int'(dout[1]), 'h1F3);

        // Same-address read during write
        wr(3, 12'h111, 3'b111); tick();
        wr(3, 12'h222, 3'b111); re = 1'b1; ra = 3; tick();
        we = 1'b0;
        check("rdw_read_first_a", int'(dout[0]), 'h111);
        check("rdw_write_first_c", int'(dout[2]), 'h222);
        tick(); idle();
        check("rdw_next_read_a", int'(dout[0]), 'h222);
        tick();
        check("rdw_write_first_b", int'(dout[1]), 'h222);
        tick();
        check("rdw_next_read_b", int'(dout[1]), 'h222);

        // Out-of-range address on the 20-word instance
        wr(25, 12'h5A5, 3'b111); tick(); idle();
        re = 1'b1; ra = 25; tick(); idle();
        check("oor_read_a_data", int'(dout[0]), 0);
        check("oor_read_a_valid", int'(vld[0]), 1);
        check("inrange_read_c", int'(dout[2]), 'h5A5);
        tick(); tick();

        // Reset pulse mid-clear, strobes while busy
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            wr(5'($urandom_range(0, 31)), 12'($urandom_range(1, 4095)), 3'b111);
            re = 1'b1; ra = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        busy_len(1'b1, cnt);
        check("restart_busy_len_a", cnt[0], 20);
        check("restart_busy_len_b", cnt[1], 32);
        check("restart_busy_len_c", cnt[2], 1);

        // Every word reads back as zero after the clear
        or_a = '0; or_b = '0; nvld_a = 0;
        for (int a = 0; a < 32; a++) begin
            re = 1'b1; ra = 5'(a); tick();
            or_a |= dout[0]; or_b |= dout[1];
            if (vld[0]) nvld_a++;
        end
        idle();
        tick(); or_b |= dout[1];
        tick();
        check("cleared_a_or", int'(or_a), 0);
        check("cleared_b_or", int'(or_b), 0);
        check("sweep_a_valid_count", nvld_a, 32);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            wm  = 3'($urandom_range(0, 7));
            din = 12'($urandom_range(0, 4095));
            tick();
        end
        rst = 1'b0; idle();
        tick(); tick();
        @(negedge clk);
        #1;
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
